// File: rtl/test_bench.sv
// APB-programmable 8-bit up/down timer with prescaler, sticky wrap flags and interrupts.
// Zero-wait APB slave; registers TDR/TCR/TSR/TIER at 0x00..0x03.
module test_bench #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tmr_ovf,
    output logic              tmr_udf
);

    localparam logic [7:0] TcrMask = 8'hB3;

    logic [7:0] tdr_q, tdr_d;
    logic [7:0] tcr_q, tcr_d;
    logic [1:0] tsr_q, tsr_d;
    logic [1:0] tier_q, tier_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] psc_q, psc_d;

    logic       addr_ok;
    logic       wr_en;
    logic [1:0] reg_sel;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       tick;
    logic       set_ovf;
    logic       set_udf;

    assign addr_ok = (paddr[ADDR_W-1:2] == '0);
    assign reg_sel = paddr[1:0];
    assign wdata   = pwdata[7:0];
    assign wr_en   = psel & penable & pwrite & addr_ok;

    assign pready  = 1'b1;
    assign pslverr = psel & penable & ~addr_ok;
    assign tmr_ovf = tsr_q[0] & tier_q[0];
    assign tmr_udf = tsr_q[1] & tier_q[1];

    always_comb begin
        rdata = 8'h00;
        if (psel && !pwrite && addr_ok) begin
            unique case (reg_sel)
                2'd0: rdata = tdr_q;
                2'd1: rdata = tcr_q;
                2'd2: rdata = {6'b0, tsr_q};
                2'd3: rdata = {6'b0, tier_q};
                default: rdata = 8'h00;
            endcase
        end
    end

    assign prdata = DATA_W'(rdata);

    // Tick when the low log2(div) prescaler bits are all ones.
    always_comb begin
        unique case (tcr_q[1:0])
            2'b00: tick = psc_q[0];
            2'b01: tick = &psc_q[1:0];
            2'b10: tick = &psc_q[2:0];
            2'b11: tick = &psc_q[3:0];
            default: tick = 1'b0;
        endcase
    end

    always_comb begin
        psc_d   = psc_q + 4'd1;
        cnt_d   = cnt_q;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (tcr_q[7]) begin
            cnt_d = tdr_q;
        end else if (tcr_q[4] && tick) begin
            if (tcr_q[5]) begin
                cnt_d   = cnt_q - 8'd1;
                set_udf = (cnt_q == 8'h00);
            end else begin
                cnt_d   = cnt_q + 8'd1;
                set_ovf = (cnt_q == 8'hFF);
            end
        end
    end

    always_comb begin
        tdr_d  = tdr_q;
        tcr_d  = tcr_q;
        tsr_d  = tsr_q;
        tier_d = tier_q;
        if (wr_en) begin
            unique case (reg_sel)
                2'd0: tdr_d  = wdata;
                2'd1: tcr_d  = wdata & TcrMask;
                2'd2: tsr_d  = tsr_q & wdata[1:0];
                2'd3: tier_d = wdata[1:0];
                default: ;
            endcase
        end
        // Hardware set takes priority over a simultaneous software clear.
        tsr_d = tsr_d | {set_udf, set_ovf};
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tdr_q  <= 8'h00;
            tcr_q  <= 8'h00;
            tsr_q  <= 2'b00;
            tier_q <= 2'b00;
            cnt_q  <= 8'h00;
            psc_q  <= 4'h0;
        end else begin
            tdr_q  <= tdr_d;
            tcr_q  <= tcr_d;
            tsr_q  <= tsr_d;
            tier_q <= tier_d;
            cnt_q  <= cnt_d;
            psc_q  <= psc_d;
        end
    end

endmodule

// File: tb/tb_test_bench.sv
// Scoreboard bench for the APB timer: reads push expected data, a monitor checks each access.
module tb_test_bench;

    logic       pclk;
    logic       preset;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       tmr_ovf;
    logic       tmr_udf;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    test_bench #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Monitor: every read access phase is checked against the oldest expectation.
    always @(negedge pclk) begin
        if (psel && penable && !pwrite) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: prdata=%h with empty scoreboard", prdata);
            end else begin
                e = exp_q.pop_front();
                if (prdata !== e.data || pslverr !== e.err || pready !== 1'b1) begin
                    bad++;
                    $display("FAIL %s: got prdata=%h pslverr=%b pready=%b, want prdata=%h pslverr=%b pready=1",
                             e.name, prdata, pslverr, pready, e.data, e.err);
                end
            end
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input string name, input logic [7:0] a,
                            input logic [7:0] d, input logic err);
        exp_t e;
        e.name = name; e.data = d; e.err = err;
        exp_q.push_back(e);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic act, input logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b, want %b", name, act, expv);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Down count from 0xFF with divider 2^(cks+1): wraps after about 256*div cycles.
    task automatic down_run(input logic [1:0] cks);
        int div;
        div = 2 << cks;
        apb_write(8'h00, 8'hFF);
        apb_write(8'h01, 8'h80 | {6'b0, cks});
        apb_write(8'h01, 8'h30 | {6'b0, cks});
        wait_cycles(256 * div - div - 10);
        apb_read($sformatf("down_pre_cks%0d", cks), 8'h02, 8'h00, 1'b0);
        wait_cycles(2 * div + 18);
        apb_read($sformatf("down_post_cks%0d", cks), 8'h02, 8'h02, 1'b0);
        apb_write(8'h01, 8'h00);
        apb_write(8'h02, 8'h00);
        apb_read($sformatf("down_clr_cks%0d", cks), 8'h02, 8'h00, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00;
        wait_cycles(3);
        check_bit("rst_pready", pready, 1'b1);
        check_bit("rst_pslverr", pslverr, 1'b0);
        check_bit("rst_tmr_ovf", tmr_ovf, 1'b0);
        check_bit("rst_tmr_udf", tmr_udf, 1'b0);
        @(negedge pclk);
        preset = 1'b0;

        apb_read("rst_tdr", 8'h00, 8'h00, 1'b0);
        apb_read("rst_tcr", 8'h01, 8'h00, 1'b0);
        apb_read("rst_tsr", 8'h02, 8'h00, 1'b0);
        apb_read("rst_tier", 8'h03, 8'h00, 1'b0);
        apb_read("bad_addr_04", 8'h04, 8'h00, 1'b1);
        apb_write(8'h40, 8'h55);
        apb_read("tdr_after_bad_wr", 8'h00, 8'h00, 1'b0);
        apb_write(8'h00, 8'hA5);
        apb_read("tdr_rw", 8'h00, 8'hA5, 1'b0);

        down_run(2'b11);
        down_run(2'b00);
        down_run(2'b01);
        down_run(2'b10);

        // Up count from 0x00 at pclk/2 overflows after about 512 cycles.
        apb_write(8'h00, 8'h00);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        wait_cycles(500);
        apb_read("up_pre", 8'h02, 8'h00, 1'b0);
        wait_cycles(20);
        apb_read("up_post", 8'h02, 8'h01, 1'b0);
        apb_write(8'h01, 8'h00);
        apb_write(8'h03, 8'h01);
        check_bit("ovf_irq_on", tmr_ovf, 1'b1);
        check_bit("udf_irq_off", tmr_udf, 1'b0);
        apb_write(8'h02, 8'hFE);
        check_bit("ovf_irq_cleared", tmr_ovf, 1'b0);
        apb_write(8'h03, 8'h00);

        // Write-0-to-clear and interrupt enable on UDF.
        apb_write(8'h00, 8'h00);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h30);
        wait_cycles(10);
        apb_write(8'h01, 8'h00);
        apb_read("udf_set", 8'h02, 8'h02, 1'b0);
        apb_write(8'h02, 8'hFF);
        apb_read("w1_no_clear", 8'h02, 8'h02, 1'b0);
        apb_write(8'h03, 8'h02);
        apb_read("tier_rd", 8'h03, 8'h02, 1'b0);
        check_bit("udf_irq_on", tmr_udf, 1'b1);
        check_bit("ovf_irq_off", tmr_ovf, 1'b0);
        apb_write(8'h03, 8'h00);
        check_bit("udf_irq_masked", tmr_udf, 1'b0);
        apb_write(8'h02, 8'hFD);
        apb_read("w0_clear", 8'h02, 8'h00, 1'b0);

        apb_write(8'h01, 8'hFF);
        apb_read("tcr_mask", 8'h01, 8'hB3, 1'b0);

        // Reset mid-count just before an underflow would occur.
        apb_write(8'h03, 8'h03);
        apb_write(8'h00, 8'h01);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h30);
        preset = 1'b1;
        wait_cycles(3);
        check_bit("midrst_udf_irq", tmr_udf, 1'b0);
        @(negedge pclk);
        preset = 1'b0;
        apb_read("midrst_tsr", 8'h02, 8'h00, 1'b0);
        apb_read("midrst_tcr", 8'h01, 8'h00, 1'b0);
        apb_read("midrst_tier", 8'h03, 8'h00, 1'b0);
        wait_cycles(600);
        apb_read("midrst_tsr_late", 8'h02, 8'h00, 1'b0);
        check_bit("midrst_udf_late", tmr_udf, 1'b0);

        wait_cycles(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
